// File: rtl/adf_spi_queue.sv
// ---------------------------------------------------------------------------
// adf_spi_queue
//
// SPI programmer for ADF-family PLL/synthesiser chips. 16-bit host writes are
// assembled into WORD_W-bit register words and queued, each tagged with a
// target chip select. Queued words are shifted out MSB-first on a shared
// SCLK/DIN pair. Each word gets its own active-low chip-select frame.
//
// Ports
//   clk_100M   sole clock, rising edge
//   clrn       asynchronous active-low reset
//   data       host write data (BUS_W)
//   wr_l       strobe: data -> low holding register
//   wr_h       strobe: push {data, lo} (truncated to WORD_W) with cs_sel
//   wr_ctl     strobe: data[0] soft clear, data[CSW+3:4] cs_sel
//   adf_cs_n   per-device chip selects, active low
//   adf_sclk   SPI clock, idles low
//   adf_din    SPI data, changes only while sclk is low
//   busy       FSM outside IDLE
//   done       one-cycle pulse on the last cycle of each word
//   fifo_cnt   queued words
//   fifo_full  fifo_cnt == DEPTH
//   ovf        sticky: a push was dropped because the queue was full
// ---------------------------------------------------------------------------
module adf_spi_queue #(
    parameter int BUS_W   = 16,
    parameter int WORD_W  = 32,
    parameter int DEPTH   = 4,
    parameter int NUM_CS  = 2,
    parameter int CLK_DIV = 25
) (
    input  logic                         clk_100M,
    input  logic                         clrn,
    input  logic [BUS_W-1:0]             data,
    input  logic                         wr_l,
    input  logic                         wr_h,
    input  logic                         wr_ctl,
    output logic [NUM_CS-1:0]            adf_cs_n,
    output logic                         adf_sclk,
    output logic                         adf_din,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt,
    output logic                         fifo_full,
    output logic                         ovf
);

    localparam int CSW   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BIT_W = $clog2(WORD_W);
    localparam int TMR_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int ENT_W = CSW + WORD_W;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TAIL,
        S_GAP
    } state_t;

    // ---------------- registers ----------------
    logic [BUS_W-1:0]  lo_q, lo_d;
    logic [CSW-1:0]    cs_sel_q, cs_sel_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CSW-1:0]    cur_cs_q, cur_cs_d;

    logic [ENT_W-1:0]  mem_q [DEPTH];

    // ---------------- combinational helpers ----------------
    logic                 soft_clr;
    logic                 pop;
    logic                 push_ok;
    logic                 full;
    logic [2*BUS_W-1:0]   push_word;
    logic [ENT_W-1:0]     push_entry;
    logic [ENT_W-1:0]     rd_entry;
    logic                 tmr_last;
    logic                 frame_active;

    assign soft_clr   = wr_ctl & data[0];
    assign full       = (cnt_q == CNT_FULL);
    assign push_word  = {data, lo_q};
    assign push_entry = {cs_sel_q, push_word[WORD_W-1:0]};
    assign rd_entry   = mem_q[rd_ptr_q];
    assign tmr_last   = (tmr_q == TMR_LAST);

    // ---------------- host side and queue bookkeeping ----------------
    always_comb begin
        lo_d     = wr_l ? data : lo_q;
        cs_sel_d = wr_ctl ? data[CSW+3:4] : cs_sel_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        // A full queue still accepts a push when a pop frees a slot this cycle.
        push_ok = wr_h && !soft_clr && (!full || pop);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (wr_h && full && !pop) begin
            ovf_d = 1'b1;
        end

        // Clear beats a simultaneous push, which is then dropped silently.
        if (soft_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end
    end

    // Queue storage carries no reset: its contents are meaningless while
    // cnt_q is zero.
    always_ff @(posedge clk_100M) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ---------------- shifter FSM ----------------
    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_last ? '0 : tmr_q + TMR_W'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        cur_cs_d = cur_cs_q;
        pop      = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (cnt_q != '0) begin
                    pop      = 1'b1;
                    shift_d  = rd_entry[WORD_W-1:0];
                    cur_cs_d = rd_entry[ENT_W-1:WORD_W];
                    bit_d    = BIT_LAST;
                    state_d  = S_LEAD;
                end
            end
            S_LEAD: begin
                if (tmr_last) begin
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tmr_last) begin
                    if (bit_q == '0) begin
                        state_d = S_TAIL;
                    end else begin
                        // Shift as LOW is entered so din settles while sclk is low.
                        shift_d = {shift_q[WORD_W-2:0], 1'b0};
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (tmr_last) begin
                    state_d = S_HIGH;
                end
            end
            S_TAIL: begin
                if (tmr_last) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (tmr_last) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (soft_clr) begin
            state_d = S_IDLE;
            tmr_d   = '0;
            pop     = 1'b0;
            done    = 1'b0;
        end
    end

    always_ff @(posedge clk_100M or negedge clrn) begin
        if (!clrn) begin
            lo_q     <= '0;
            cs_sel_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            cur_cs_q <= '0;
        end else begin
            lo_q     <= lo_d;
            cs_sel_q <= cs_sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            cur_cs_q <= cur_cs_d;
        end
    end

    // ---------------- outputs ----------------
    // Pin outputs decode straight from the state register so an asynchronous
    // reset or a soft clear drives them to idle levels without extra latency.
    assign frame_active = (state_q == S_LEAD) || (state_q == S_HIGH) ||
                          (state_q == S_LOW)  || (state_q == S_TAIL);
    assign adf_sclk     = (state_q == S_HIGH);
    assign adf_din      = frame_active & shift_q[WORD_W-1];
    assign busy         = (state_q != S_IDLE);
    assign fifo_cnt     = cnt_q;
    assign fifo_full    = full;
    assign ovf          = ovf_q;

    // A cs_sel value with no matching index leaves every select high.
    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign adf_cs_n[gi] = !(frame_active && (cur_cs_q == CSW'(gi)));
        end
    endgenerate

endmodule

// File: tb/tb_adf_spi_queue.sv
module tb_adf_spi_queue;

    localparam int BUS_W   = 16;
    localparam int WORD_W  = 32;
    localparam int DEPTH   = 4;
    localparam int NUM_CS  = 3;
    localparam int CLK_DIV = 2;
    localparam int FRAME_LEN = CLK_DIV * (2 * WORD_W + 2);

    logic              clk_100M = 1'b0;
    logic              clrn     = 1'b0;
    logic [BUS_W-1:0]  data     = '0;
    logic              wr_l     = 1'b0;
    logic              wr_h     = 1'b0;
    logic              wr_ctl   = 1'b0;
    logic [NUM_CS-1:0] adf_cs_n;
    logic              adf_sclk;
    logic              adf_din;
    logic              busy;
    logic              done;
    logic [2:0]        fifo_cnt;
    logic              fifo_full;
    logic              ovf;

    adf_spi_queue #(
        .BUS_W  (BUS_W),
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .NUM_CS (NUM_CS),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk_100M (clk_100M),
        .clrn     (clrn),
        .data     (data),
        .wr_l     (wr_l),
        .wr_h     (wr_h),
        .wr_ctl   (wr_ctl),
        .adf_cs_n (adf_cs_n),
        .adf_sclk (adf_sclk),
        .adf_din  (adf_din),
        .busy     (busy),
        .done     (done),
        .fifo_cnt (fifo_cnt),
        .fifo_full(fifo_full),
        .ovf      (ovf)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [1:0]  cs;
        logic [31:0] exp_word;
        logic [2:0]  exp_mask;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        int          edges;
        int          len;
        int          dones;
        int          gap;
        logic [2:0]  mask;
    } frame_t;

    frame_t      frames[$];
    int          checks = 0;
    int          errors = 0;
    int          cur_edges = 0;
    int          done_total = 0;
    int          din_viol = 0;

    // monitor state
    bit          in_frame = 1'b0;
    frame_t      cur;
    logic        sclk_prev = 1'b0;
    logic        din_prev = 1'b0;
    int          cs_high_run = 0;

    vec_t        vecs[5];
    logic [31:0] b2b[5];

    // Frame monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        cur.word = '0; cur.edges = 0; cur.len = 0; cur.dones = 0; cur.gap = 0; cur.mask = '0;
        forever begin
            @(negedge clk_100M);
            if (!clrn) begin
                in_frame    = 1'b0;
                cur_edges   = 0;
                cs_high_run = 0;
            end else begin
                if (busy) begin
                    if (!in_frame) begin
                        in_frame  = 1'b1;
                        cur.word  = '0;
                        cur.edges = 0;
                        cur.len   = 0;
                        cur.dones = 0;
                        cur.mask  = '0;
                        cur.gap   = cs_high_run;
                        cur_edges = 0;
                    end
                    cur.len++;
                    if (adf_sclk && !sclk_prev) begin
                        cur.word = {cur.word[30:0], adf_din};
                        cur.edges++;
                        cur_edges = cur.edges;
                    end
                    cur.mask = cur.mask | ~adf_cs_n;
                    if (done) cur.dones++;
                end else if (in_frame) begin
                    in_frame = 1'b0;
                    frames.push_back(cur);
                end
                if (adf_sclk && sclk_prev && (adf_din != din_prev)) din_viol++;
                cs_high_run = (&adf_cs_n) ? cs_high_run + 1 : 0;
                if (done) done_total++;
            end
            sclk_prev = adf_sclk;
            din_prev  = adf_din;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called on a falling edge; leaves on the next falling edge.
    task automatic strobe(input logic l, input logic h, input logic c, input logic [15:0] d);
        wr_l = l; wr_h = h; wr_ctl = c; data = d;
        @(negedge clk_100M);
        wr_l = 1'b0; wr_h = 1'b0; wr_ctl = 1'b0; data = '0;
    endtask

    task automatic push(input logic [15:0] lo, input logic [15:0] hi);
        strobe(1'b1, 1'b0, 1'b0, lo);
        strobe(1'b0, 1'b1, 1'b0, hi);
    endtask

    task automatic ctl(input logic [1:0] cs, input logic clr);
        strobe(1'b0, 1'b0, 1'b1, {10'b0, cs, 3'b0, clr});
    endtask

    task automatic wait_frame(input string name, output frame_t f);
        int n = 0;
        f.word = '0; f.edges = 0; f.len = 0; f.dones = 0; f.gap = 0; f.mask = '0;
        while (frames.size() == 0 && n < 2000) begin
            @(negedge clk_100M);
            n++;
        end
        if (frames.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no frame completed within %0d cycles", name, n);
        end else begin
            f = frames.pop_front();
        end
    endtask

    // Wait for a new frame to start, then for n rising sclk edges in it.
    task automatic wait_edges(input string name, input int n_edges);
        int n = 0;
        while (!busy && n < 100) begin
            @(negedge clk_100M);
            n++;
        end
        @(negedge clk_100M);
        while (cur_edges < n_edges && n < 600) begin
            @(negedge clk_100M);
            n++;
        end
        checks++;
        if (cur_edges < n_edges) begin
            errors++;
            $display("FAIL %s: reached %0d sclk edges, required %0d", name, cur_edges, n_edges);
        end
    endtask

    task automatic check_frame(input string name, input frame_t f,
                               input logic [31:0] exp_word, input logic [2:0] exp_mask);
        chk({name, "_word"},  f.word,  exp_word);
        chk({name, "_edges"}, f.edges, WORD_W);
        chk({name, "_len"},   f.len,   FRAME_LEN);
        chk({name, "_mask"},  {29'b0, f.mask}, {29'b0, exp_mask});
        chk({name, "_done"},  f.dones, 1);
        $display("frame %s: word=0x%08h edges=%0d len=%0d mask=%b dones=%0d gap=%0d",
                 name, f.word, f.edges, f.len, f.mask, f.dones, f.gap);
    endtask

    initial begin : main
        frame_t f;
        int d0;

        vecs[0] = '{16'h0005, 16'h0058, 2'd0, 32'h0058_0005, 3'b001};
        vecs[1] = '{16'h5A5A, 16'hA5A5, 2'd1, 32'hA5A5_5A5A, 3'b010};
        vecs[2] = '{16'hFFFF, 16'h8000, 2'd2, 32'h8000_FFFF, 3'b100};
        vecs[3] = '{16'h1234, 16'h0001, 2'd3, 32'h0001_1234, 3'b000};
        vecs[4] = '{16'h0001, 16'h0000, 2'd0, 32'h0000_0001, 3'b001};
        b2b[0] = 32'h1111_0001;
        b2b[1] = 32'h2222_8002;
        b2b[2] = 32'hF0F0_0F0F;
        b2b[3] = 32'h0000_FFFF;
        b2b[4] = 32'h8001_7FFE;

        // ---- reset values ----
        repeat (3) @(negedge clk_100M);
        chk("rst_cs_n", {29'b0, adf_cs_n}, 32'h7);
        chk("rst_sclk", {31'b0, adf_sclk}, 32'h0);
        chk("rst_din",  {31'b0, adf_din},  32'h0);
        chk("rst_busy", {31'b0, busy},     32'h0);
        chk("rst_done", {31'b0, done},     32'h0);
        chk("rst_cnt",  {29'b0, fifo_cnt}, 32'h0);
        chk("rst_full", {31'b0, fifo_full}, 32'h0);
        chk("rst_ovf",  {31'b0, ovf},      32'h0);
        clrn = 1'b1;
        repeat (2) @(negedge clk_100M);
        chk("idle_busy", {31'b0, busy}, 32'h0);

        // ---- table-driven single words: latency, frame content, chip select ----
        for (int i = 0; i < 5; i++) begin
            ctl(vecs[i].cs, 1'b0);
            push(vecs[i].lo, vecs[i].hi);
            chk($sformatf("v%0d_cnt_t1", i),  {29'b0, fifo_cnt}, 32'h1);
            chk($sformatf("v%0d_busy_t1", i), {31'b0, busy}, 32'h0);
            @(negedge clk_100M);
            chk($sformatf("v%0d_busy_t2", i), {31'b0, busy}, 32'h1);
            chk($sformatf("v%0d_cs_t2", i),   {29'b0, adf_cs_n}, {29'b0, ~vecs[i].exp_mask});
            chk($sformatf("v%0d_cnt_t2", i),  {29'b0, fifo_cnt}, 32'h0);
            wait_frame($sformatf("v%0d", i), f);
            check_frame($sformatf("v%0d", i), f, vecs[i].exp_word, vecs[i].exp_mask);
            chk($sformatf("v%0d_busy_end", i), {31'b0, busy}, 32'h0);
        end

        // ---- five back-to-back words while the first is shifting ----
        ctl(2'd0, 1'b0);
        for (int k = 0; k < 5; k++) push(b2b[k][15:0], b2b[k][31:16]);
        chk("b2b_ovf", {31'b0, ovf}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            wait_frame($sformatf("b2b%0d", k), f);
            check_frame($sformatf("b2b%0d", k), f, b2b[k], 3'b001);
            if (k > 0) chk($sformatf("b2b%0d_gap", k), f.gap, CLK_DIV + 1);
        end
        chk("b2b_ovf_end", {31'b0, ovf}, 32'h0);

        // ---- overflow with the FSM busy, then soft clear ----
        for (int k = 0; k < 5; k++) push(16'h1000 + 16'(k), 16'h0ABC);
        chk("ovf_full", {31'b0, fifo_full}, 32'h1);
        chk("ovf_cnt4", {29'b0, fifo_cnt}, 32'h4);
        chk("ovf_pre",  {31'b0, ovf}, 32'h0);
        push(16'h1005, 16'h0ABC);
        chk("ovf_set",  {31'b0, ovf}, 32'h1);
        chk("ovf_cnt_hold", {29'b0, fifo_cnt}, 32'h4);
        d0 = done_total;
        ctl(2'd0, 1'b1);
        chk("clr_cnt",  {29'b0, fifo_cnt}, 32'h0);
        chk("clr_ovf",  {31'b0, ovf}, 32'h0);
        chk("clr_full", {31'b0, fifo_full}, 32'h0);
        chk("clr_busy", {31'b0, busy}, 32'h0);
        chk("clr_cs",   {29'b0, adf_cs_n}, 32'h7);
        chk("clr_sclk", {31'b0, adf_sclk}, 32'h0);
        repeat (3) @(negedge clk_100M);
        frames.delete();
        repeat (300) @(negedge clk_100M);
        chk("clr_no_frames", frames.size(), 0);
        chk("clr_no_done", done_total, d0);

        // ---- soft clear during the 10th bit ----
        push(16'hC3C3, 16'h3C3C);
        wait_edges("bit10_reach", 10);
        d0 = done_total;
        ctl(2'd0, 1'b1);
        chk("bit10_cs",   {29'b0, adf_cs_n}, 32'h7);
        chk("bit10_sclk", {31'b0, adf_sclk}, 32'h0);
        chk("bit10_din",  {31'b0, adf_din},  32'h0);
        chk("bit10_busy", {31'b0, busy}, 32'h0);
        chk("bit10_cnt",  {29'b0, fifo_cnt}, 32'h0);
        repeat (50) @(negedge clk_100M);
        chk("bit10_no_done", done_total, d0);
        frames.delete();

        // ---- clear in the same cycle as wr_h: push dropped, cs_sel taken ----
        strobe(1'b1, 1'b0, 1'b0, 16'h7777);
        strobe(1'b0, 1'b1, 1'b1, 16'h0011);
        chk("clrh_cnt", {29'b0, fifo_cnt}, 32'h0);
        chk("clrh_ovf", {31'b0, ovf}, 32'h0);
        @(negedge clk_100M);
        chk("clrh_busy", {31'b0, busy}, 32'h0);
        push(16'h2222, 16'h4444);
        wait_frame("clrh_next", f);
        check_frame("clrh_next", f, 32'h4444_2222, 3'b010);

        // ---- asynchronous reset mid-frame ----
        ctl(2'd0, 1'b0);
        push(16'hAAAA, 16'h5555);
        push(16'hBBBB, 16'h6666);
        wait_edges("rstmid_reach", 5);
        clrn = 1'b0;
        #1;
        chk("rstmid_cs",   {29'b0, adf_cs_n}, 32'h7);
        chk("rstmid_sclk", {31'b0, adf_sclk}, 32'h0);
        chk("rstmid_din",  {31'b0, adf_din},  32'h0);
        chk("rstmid_busy", {31'b0, busy}, 32'h0);
        chk("rstmid_done", {31'b0, done}, 32'h0);
        chk("rstmid_cnt",  {29'b0, fifo_cnt}, 32'h0);
        chk("rstmid_ovf",  {31'b0, ovf}, 32'h0);
        @(negedge clk_100M);
        clrn = 1'b1;
        frames.delete();
        repeat (400) @(negedge clk_100M);
        chk("rstmid_no_frames", frames.size(), 0);
        chk("rstmid_busy_end", {31'b0, busy}, 32'h0);

        chk("din_stable_while_sclk_high", din_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
